// File: rtl/fp_cmp_pipe_if.sv
// rtl/fp_cmp_pipe_if.sv - operation/result handshake bundle for the FP compare/min/max pipe
interface fp_cmp_pipe_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_flush;
    logic                  in_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] in_numA;
    logic [DATA_WIDTH-1:0] in_numB;
    logic [2:0]            in_op;
    logic                  in_fmt;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_flag_NV;
    logic [TAG_WIDTH-1:0]  out_tag;

    // Issuing side: drives operations, accepts results.
    modport master (
        output in_flush, in_valid, in_numA, in_numB, in_op, in_fmt, in_tag, in_ready,
        input  out_ready, out_valid, out_data, out_flag_NV, out_tag
    );

    // Compare unit side.
    modport slave (
        input  in_flush, in_valid, in_numA, in_numB, in_op, in_fmt, in_tag, in_ready,
        output out_ready, out_valid, out_data, out_flag_NV, out_tag
    );
endinterface

// File: rtl/fp_cmp_pipe.sv
// rtl/fp_cmp_pipe.sv - two-stage IEEE-754 FEQ/FLT/FLE/FMIN/FMAX pipeline with tag passthrough
module fp_cmp_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    fp_cmp_pipe_if.slave      bus
);
    localparam logic [2:0]  OP_FLE  = 3'b000;
    localparam logic [2:0]  OP_FLT  = 3'b001;
    localparam logic [2:0]  OP_FEQ  = 3'b010;
    localparam logic [2:0]  OP_FMIN = 3'b011;
    localparam logic [2:0]  OP_FMAX = 3'b100;
    localparam logic [63:0] CANON_D = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] CANON_S = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [31:0] QNAN_S  = 32'h7FC0_0000;

    // Stage 1: captured operation
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;
    logic [2:0]            r_s1_op;
    logic                  r_s1_fmt;
    logic [TAG_WIDTH-1:0]  r_s1_tag;

    // Stage 2: registered result driving the outputs
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic                  r_s2_nv;
    logic [TAG_WIDTH-1:0]  r_s2_tag;

    logic w_stall;
    logic w_accept;
    logic w_advance;

    // S2 is held while a result waits on the consumer; S1 may still fill if empty.
    assign w_stall       = r_s2_valid & ~bus.in_ready;
    assign w_advance     = ~w_stall;
    assign bus.out_ready = (~w_stall | ~r_s1_valid) & ~bus.in_flush;
    assign w_accept      = bus.in_valid & bus.out_ready;

    // Operands widened to 64 bits so one datapath serves both DATA_WIDTH settings.
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_dbl;
    logic        w_a_boxed;
    logic        w_b_boxed;
    logic [31:0] w_a_s;
    logic [31:0] w_b_s;
    logic [63:0] w_a_val;
    logic [63:0] w_b_val;

    assign w_a_ext   = 64'(r_s1_a);
    assign w_b_ext   = 64'(r_s1_b);
    assign w_dbl     = (DATA_WIDTH == 64) && r_s1_fmt;
    assign w_a_boxed = (DATA_WIDTH == 32) || (&w_a_ext[63:32]);
    assign w_b_boxed = (DATA_WIDTH == 32) || (&w_b_ext[63:32]);
    // An improperly boxed single is seen as the canonical quiet NaN.
    assign w_a_s     = w_a_boxed ? w_a_ext[31:0] : QNAN_S;
    assign w_b_s     = w_b_boxed ? w_b_ext[31:0] : QNAN_S;
    // Values as they would be returned by FMIN/FMAX (singles re-boxed).
    assign w_a_val   = w_dbl ? w_a_ext : {32'hFFFF_FFFF, w_a_s};
    assign w_b_val   = w_dbl ? w_b_ext : {32'hFFFF_FFFF, w_b_s};

    logic        w_a_sign;
    logic        w_b_sign;
    logic [62:0] w_a_mag;
    logic [62:0] w_b_mag;
    logic        w_a_nan;
    logic        w_b_nan;
    logic        w_a_snan;
    logic        w_b_snan;
    logic        w_a_zero;
    logic        w_b_zero;

    // Classify both operands in a format-neutral sign/magnitude form.
    always_comb begin
        w_a_sign = w_dbl ? w_a_ext[63] : w_a_s[31];
        w_b_sign = w_dbl ? w_b_ext[63] : w_b_s[31];
        w_a_mag  = w_dbl ? w_a_ext[62:0] : {32'd0, w_a_s[30:0]};
        w_b_mag  = w_dbl ? w_b_ext[62:0] : {32'd0, w_b_s[30:0]};
        w_a_nan  = w_dbl ? ((&w_a_ext[62:52]) & (|w_a_ext[51:0]))
                         : ((&w_a_s[30:23]) & (|w_a_s[22:0]));
        w_b_nan  = w_dbl ? ((&w_b_ext[62:52]) & (|w_b_ext[51:0]))
                         : ((&w_b_s[30:23]) & (|w_b_s[22:0]));
        w_a_snan = w_a_nan & ~(w_dbl ? w_a_ext[51] : w_a_s[22]);
        w_b_snan = w_b_nan & ~(w_dbl ? w_b_ext[51] : w_b_s[22]);
        w_a_zero = (w_a_mag == 63'd0);
        w_b_zero = (w_b_mag == 63'd0);
    end

    logic        w_mag_lt;
    logic        w_mag_gt;
    logic        w_lt;
    logic        w_eq;
    logic        w_lt_mm;
    logic        w_any_nan;
    logic        w_any_snan;
    logic [63:0] w_res;
    logic        w_res_nv;

    // Compare and select the result for the operation held in S1.
    always_comb begin
        w_mag_lt   = (w_a_mag < w_b_mag);
        w_mag_gt   = (w_a_mag > w_b_mag);
        w_any_nan  = w_a_nan | w_b_nan;
        w_any_snan = w_a_snan | w_b_snan;
        // IEEE ordering: zeros of either sign are equal.
        if (w_a_sign != w_b_sign) begin
            w_lt = w_a_sign & ~(w_a_zero & w_b_zero);
        end else begin
            w_lt = w_a_sign ? w_mag_gt : w_mag_lt;
        end
        w_eq = (w_a_val == w_b_val) | (w_a_zero & w_b_zero);
        // Min/max ordering: -0 sorts below +0.
        if (w_a_sign != w_b_sign) begin
            w_lt_mm = w_a_sign;
        end else begin
            w_lt_mm = w_a_sign ? w_mag_gt : w_mag_lt;
        end

        w_res    = 64'd0;
        w_res_nv = 1'b0;
        case (r_s1_op)
            OP_FEQ: begin
                w_res    = {63'd0, ~w_any_nan & w_eq};
                w_res_nv = w_any_snan;
            end
            OP_FLT: begin
                w_res    = {63'd0, ~w_any_nan & w_lt};
                w_res_nv = w_any_nan;
            end
            OP_FLE: begin
                w_res    = {63'd0, ~w_any_nan & (w_lt | w_eq)};
                w_res_nv = w_any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                w_res_nv = w_any_snan;
                if (w_a_nan & w_b_nan) begin
                    w_res = w_dbl ? CANON_D : CANON_S;
                end else if (w_a_nan) begin
                    w_res = w_b_val;
                end else if (w_b_nan) begin
                    w_res = w_a_val;
                end else if (r_s1_op == OP_FMIN) begin
                    w_res = w_lt_mm ? w_a_val : w_b_val;
                end else begin
                    w_res = w_lt_mm ? w_b_val : w_a_val;
                end
            end
            default: begin
                w_res    = 64'd0;
                w_res_nv = 1'b0;
            end
        endcase
    end

    // Stage 1 register: load on accept, drain when the entry moves to S2.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= 3'd0;
            r_s1_fmt   <= 1'b0;
            r_s1_tag   <= '0;
        end else if (bus.in_flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= bus.in_numA;
            r_s1_b     <= bus.in_numB;
            r_s1_op    <= bus.in_op;
            r_s1_fmt   <= bus.in_fmt;
            r_s1_tag   <= bus.in_tag;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2 register: capture the result unless the consumer is stalling.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_nv    <= 1'b0;
            r_s2_tag   <= '0;
        end else if (bus.in_flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_res[DATA_WIDTH-1:0];
                r_s2_nv   <= w_res_nv;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign bus.out_valid   = r_s2_valid;
    assign bus.out_data    = r_s2_data;
    assign bus.out_flag_NV = r_s2_nv;
    assign bus.out_tag     = r_s2_tag;
endmodule

// File: doc/fp_cmp_pipe.md
Name: fp_cmp_pipe

Overview:
- Pipelined, parametrised floating-point compare and min/max unit for the FP_Unit. It executes FEQ, FLT, FLE, FMIN and FMAX on single- or double-precision operands.
- Results are IEEE-754 correct: sign-magnitude ordering, -0 == +0, quiet/signaling NaN distinction.
- Two-stage valid/ready pipeline. A tag travels alongside each operation for writeback.

Parameters:
- DATA_WIDTH, 64, operand/result width; legal values 32 (single only, in_fmt ignored) or 64.
- TAG_WIDTH, 5, width of the opaque tag (destination register index) passed through with each operation.

Ports:
- in_clk  input  1  clock.
- in_rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
- in_flush  input  1  synchronous flush; kills all in-flight operations.
- in_valid  input  1  upstream operation valid.
- out_ready  output  1  unit can accept an operation this cycle.
- in_numA  input  DATA_WIDTH  operand A.
- in_numB  input  DATA_WIDTH  operand B.
- in_op  input  3  000 FLE, 001 FLT, 010 FEQ, 011 FMIN, 100 FMAX, others reserved.
- in_fmt  input  1  0 single (bits [31:0]), 1 double.
- in_tag  input  TAG_WIDTH  passthrough tag.
- out_valid  output  1  result valid.
- in_ready  input  1  downstream accepts the result.
- out_data  output  DATA_WIDTH  result.
- out_flag_NV  output  1  invalid-operation flag for this result.
- out_tag  output  TAG_WIDTH  tag of this result.

Behaviour:
- Reset (async, in_rst_n=0): both stage valid bits 0, out_valid=0, out_data=0, out_flag_NV=0, out_tag=0. Reset is legal mid-operation; in-flight operations are discarded and no result appears after release.
- Pipeline: S1 registers operands/op/fmt/tag; classification and compare run between S1 and S2; S2 drives the out_* ports. Latency is 2 cycles from accept to out_valid with no stall. Throughput is 1 operation per cycle.
- Handshake:
  - An operation is accepted when in_valid & out_ready.
  - A result is consumed when out_valid & in_ready.
  - stall = out_valid & !in_ready.
  - out_ready = !stall | !S1_valid. This allows S1 to fill while S2 is held.
  - While stalled, S2 holds its data, flag and tag stable and S1 holds its contents.
  - No operation is lost, duplicated or reordered.
- Flush: in_flush=1 clears S1_valid and out_valid at the next edge. An operation presented in the same cycle as the flush is not accepted: out_ready=0 while in_flush=1.
- Single operands with DATA_WIDTH=64:
  - An operand is valid only if NaN-boxed (bits [63:32] all ones).
  - An unboxed operand is treated as canonical qNaN 0x7FC00000.
  - Compare/NaN logic uses bits [31:0] with an 8-bit exponent and 23-bit mantissa.
- Classification:
  - NaN: exponent all ones and mantissa nonzero.
  - sNaN: NaN with mantissa MSB 0.
  - zero: exponent 0 and mantissa 0.
- Ordering: A<B is decided by sign-magnitude.
  - Signs differ: A<B iff A negative and not both zero.
  - Both positive: A<B iff magA<magB.
  - Both negative: A<B iff magA>magB.
  - A==B iff bit-equal, or both zero regardless of sign.
- FEQ/FLT/FLE: out_data = zero-extended 1 or 0. Any NaN operand gives 0.
  - FEQ: NV=1 only if an operand is sNaN.
  - FLT/FLE: NV=1 if any operand is NaN.
- FMIN/FMAX:
  - For min/max ordering, -0 < +0.
  - One NaN operand: result is the other operand.
  - Both NaN: result is the canonical NaN (double 0x7FF8000000000000; single 0x7FC00000).
  - NV=1 if either operand is sNaN.
  - Single results are NaN-boxed (upper 32 bits ones) when DATA_WIDTH=64.
- Reserved in_op: out_data=0, out_flag_NV=0; the operation still flows through and produces out_valid.
- DATA_WIDTH=32: in_fmt ignored, no NaN-box check, results are 32-bit.

Test Plan:
- FLT single, A=0xFFFFFFFFC0000000 (-2.0), B=0xFFFFFFFFBF800000 (-1.0) -> out_data=1, NV=0, out_valid 2 cycles after accept; swap operands -> 0.
- FEQ single, A=0xFFFFFFFF80000000 (-0), B=0xFFFFFFFF00000000 (+0) -> out_data=1. FMAX on the same operands -> 0xFFFFFFFF00000000. FMIN -> 0xFFFFFFFF80000000.
- NaN handling, single: FEQ A=0xFFFFFFFF7FC00000, B=0xFFFFFFFF3F800000 -> 0, NV=0. FLT on the same operands -> 0, NV=1. FEQ with A=0xFFFFFFFF7F800001 (sNaN) -> NV=1. Unboxed A=0x000000003F800000 with FEQ against 1.0 -> 0.
- FMIN double, A=0x7FF4000000000000 (sNaN), B=0x7FF8000000000001 -> 0x7FF8000000000000, NV=1. A=NaN, B=0x4000000000000000 -> 0x4000000000000000.
- Backpressure: 4 back-to-back ops tagged 1..4, in_ready held low for 3 cycles after the first result -> out_ready drops once S1 is full, out_* held stable; all 4 results emerge in order with correct tags and no duplicates.
- Reset/flush: async reset asserted mid-stream -> out_valid=0 immediately, no stale result after release. in_flush with 2 ops in flight -> out_valid=0 next cycle, and the following accepted op returns normally.
